// File: rtl/rv_pkg.sv
// Shared RV64 load/store definitions: funct3 encodings, LSU state encoding
// and access-size helpers used by the LSU datapath and control.
package rv_pkg;

  localparam logic [2:0] LSU_B  = 3'd0;
  localparam logic [2:0] LSU_H  = 3'd1;
  localparam logic [2:0] LSU_W  = 3'd2;
  localparam logic [2:0] LSU_D  = 3'd3;
  localparam logic [2:0] LSU_BU = 3'd4;
  localparam logic [2:0] LSU_HU = 3'd5;
  localparam logic [2:0] LSU_WU = 3'd6;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_t;

  // Byte-lane mask of an access before shifting to its offset.
  function automatic logic [7:0] lsu_lane_mask(input logic [2:0] f3);
    logic [7:0] m;
    case (f3)
      LSU_B, LSU_BU: m = 8'h01;
      LSU_H, LSU_HU: m = 8'h03;
      LSU_W, LSU_WU: m = 8'h0F;
      default:       m = 8'hFF;
    endcase
    return m;
  endfunction

  // Misaligned or illegal encodings; unsigned halfwords align like H.
  function automatic logic lsu_err(input logic we, input logic [2:0] f3,
                                   input logic [2:0] off);
    logic e;
    case (f3)
      LSU_B, LSU_BU: e = 1'b0;
      LSU_H, LSU_HU: e = off[0];
      LSU_W, LSU_WU: e = |off[1:0];
      LSU_D:         e = |off;
      default:       e = 1'b1;
    endcase
    if (we && f3[2]) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational byte-lane datapath: little-endian load extract/extend and
// sub-doubleword store merge into an existing doubleword.
module rv_lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]        off,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] merged
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] wshift;
  logic [7:0]        lanes;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      LSU_B:   result = {{56{shifted[7]}},  shifted[7:0]};
      LSU_H:   result = {{48{shifted[15]}}, shifted[15:0]};
      LSU_W:   result = {{32{shifted[31]}}, shifted[31:0]};
      LSU_BU:  result = {56'd0, shifted[7:0]};
      LSU_HU:  result = {48'd0, shifted[15:0]};
      LSU_WU:  result = {32'd0, shifted[31:0]};
      default: result = shifted;
    endcase

    lanes  = lsu_lane_mask(funct3) << off;
    wshift = wdata << {off, 3'b000};
    merged = rdata;
    for (int i = 0; i < 8; i++) begin
      if (lanes[i]) merged[8*i +: 8] = wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/rv_lsu.sv
// RV64 MEM-stage load/store unit: one request at a time, read-modify-write
// for partial stores, all outputs driven from registers.
module rv_lsu
  import rv_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [63:0] mem_wr_data,
  input  logic [63:0] mem_rd_data
);

  lsu_state_t  state;
  logic [1:0]  cnt;
  logic        we_p0;
  logic [2:0]  f3_p0;
  logic [2:0]  off_p0;
  logic [63:0] wdata_p0;
  logic [63:0] ld_result;
  logic [63:0] st_merged;
  logic        acc_err;

  assign acc_err = lsu_err(req_we, req_funct3, req_addr[2:0]);

  rv_lsu_align u_align (
    .off    (off_p0),
    .funct3 (f3_p0),
    .rdata  (mem_rd_data),
    .wdata  (wdata_p0),
    .result (ld_result),
    .merged (st_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      we_p0       <= 1'b0;
      f3_p0       <= '0;
      off_p0      <= '0;
      wdata_p0    <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      case (state)
        // p0: accept and latch the request
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_p0     <= req_we;
            f3_p0     <= req_funct3;
            off_p0    <= req_addr[2:0];
            wdata_p0  <= req_wdata;
            if (acc_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && req_funct3 == LSU_D) begin
              state       <= ST_WR;
              mem_addr    <= {req_addr[31:3], 3'b000};
              mem_wr_en   <= 1'b1;
              mem_wr_data <= req_wdata;
            end else begin
              state     <= ST_RD;
              mem_addr  <= {req_addr[31:3], 3'b000};
              mem_rd_en <= 1'b1;
            end
          end
        end
        ST_RD: begin
          mem_rd_en <= 1'b0;
          cnt       <= 2'(RD_LAT - 1);
          state     <= ST_WAIT;
        end
        // p1: read data lands in the last wait cycle
        ST_WAIT: begin
          if (cnt == 2'd0) begin
            if (we_p0) begin
              state       <= ST_WR;
              mem_wr_en   <= 1'b1;
              mem_wr_data <= st_merged;
            end else begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= ld_result;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_WR: begin
          mem_wr_en <= 1'b0;
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        // p2: single completion pulse, then idle
        ST_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Randomized scoreboard bench for rv_lsu against a byte-level memory model;
// a second instance with three-cycle read latency checks load timing.
module tb_rv_lsu;

  localparam int L = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_err, mem_rd_en, mem_wr_en;
  logic [63:0] rsp_rdata, mem_wr_data, mem_rd_data;
  logic [31:0] mem_addr;

  logic        req_valid3, req_ready3;
  logic [31:0] req_addr3;
  logic        rsp_valid3, rsp_err3, mem_rd_en3, mem_wr_en3;
  logic [63:0] rsp_rdata3, mem_wr_data3, mem_rd_data3;
  logic [31:0] mem_addr3;

  rv_lsu #(.RD_LAT(L)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  rv_lsu #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(1'b0), .req_funct3(3'd0), .req_addr(req_addr3),
    .req_wdata(64'd0), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3),
    .rsp_err(rsp_err3), .mem_addr(mem_addr3), .mem_rd_en(mem_rd_en3),
    .mem_wr_en(mem_wr_en3), .mem_wr_data(mem_wr_data3), .mem_rd_data(mem_rd_data3)
  );

  // Memory: 64 doublewords, read data appears RD_LAT cycles after the strobe.
  logic [63:0] mem     [0:63];
  logic [63:0] ref_mem [0:63];
  logic [63:0] rdp  [L];
  logic [63:0] rdp3 [3];
  assign mem_rd_data  = rdp[L-1];
  assign mem_rd_data3 = rdp3[2];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[8:3]] <= mem_wr_data;
    for (int i = L - 1; i > 0; i--) rdp[i] <= rdp[i-1];
    rdp[0] <= mem_rd_en ? mem[mem_addr[8:3]] : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 2; i > 0; i--) rdp3[i] <= rdp3[i-1];
    rdp3[0] <= mem_rd_en3 ? mem[mem_addr3[8:3]] : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
    int          nrd;
    int          nwr;
    logic [31:0] maddr;
    logic [63:0] wdata;
  } exp_t;

  exp_t q[$];
  int   nrd = 0;
  int   nwr = 0;

  // Reference: byte-addressed view of memory, sizes and latency from the rules.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [63:0] wd);
    exp_t e;
    int size, off, idx;
    logic [63:0] dw, v;
    size = 1 << (f3 % 4);
    off  = int'(a[2:0]);
    idx  = int'(a[8:3]);
    e.maddr = {a[31:3], 3'b000};
    e.rdata = 0; e.err = 0; e.nrd = 0; e.nwr = 0; e.wdata = 0; e.cyc = 0;
    if (f3 == 3'd7 || (we && f3 >= 3'd4) || (off % size) != 0) begin
      e.err = 1; e.cyc = 1;
    end else if (!we) begin
      dw = ref_mem[idx];
      v = 0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = dw[8*(off+k) +: 8];
      if (f3 < 3'd4 && size < 8 && v[8*size-1])
        for (int k = size; k < 8; k++) v[8*k +: 8] = 8'hFF;
      e.rdata = v; e.nrd = 1; e.cyc = 2 + L;
    end else begin
      dw = ref_mem[idx];
      for (int k = 0; k < size; k++) dw[8*(off+k) +: 8] = wd[8*k +: 8];
      ref_mem[idx] = dw;
      e.wdata = dw; e.nwr = 1;
      e.nrd = (size == 8) ? 0 : 1;
      e.cyc = (size == 8) ? 2 : 3 + L;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en && mem_wr_en) chk("both_strobes", 64'd1, 64'd0);
      if (mem_rd_en || mem_wr_en) begin
        if (q.size() == 0) chk("strobe_without_request", 64'd1, 64'd0);
        else begin
          chk("mem_addr", 64'(mem_addr), 64'(q[0].maddr));
          if (mem_wr_en) chk("mem_wr_data", mem_wr_data, q[0].wdata);
        end
        if (mem_rd_en) nrd++;
        if (mem_wr_en) nwr++;
      end
      if (rsp_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
          chk("rd_strobes", 64'(nrd), 64'(e.nrd));
          chk("wr_strobes", 64'(nwr), 64'(e.nwr));
        end
        nrd = 0;
        nwr = 0;
      end
    end
  end

  // Called #1 after a rising edge; leaves req_valid high after the accept.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, output int t0);
    exp_t e;
    int n = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    t0 = -1;
    if (!req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      e = model(we, f3, a, wd);
      e.cyc += cyc;
      t0 = cyc;
      q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while ((q.size() != 0 || !req_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  int t0, t1, n;
  logic [63:0] saved;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 64'd0;
    req_valid3 = 1'b0; req_addr3 = 32'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = {$urandom(), $urandom()};
      ref_mem[i] = mem[i];
    end
    mem[32] = 64'h8877_6655_4433_2211;
    ref_mem[32] = mem[32];
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_outs", {rsp_rdata | mem_wr_data}, 64'd0);
    chk("reset_strobes", 64'({rsp_err, mem_rd_en, mem_wr_en}), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Three-cycle read latency instance: LB 0x107 completes at T5.
    req_valid3 = 1'b1; req_addr3 = 32'h107;
    t0 = cyc;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid3 && n < 20) begin @(negedge clk); n++; end
    chk("lat3_rsp_cycle", 64'(cyc), 64'(t0 + 5));
    chk("lat3_rdata", rsp_rdata3, 64'hFFFF_FFFF_FFFF_FF88);
    chk("lat3_err", 64'(rsp_err3), 64'd0);
    @(posedge clk); #1;

    // Directed loads, partial and full stores, misaligned access.
    issue(1'b0, 3'd0, 32'h107, 64'd0, t0);
    issue(1'b0, 3'd4, 32'h107, 64'd0, t0);
    issue(1'b0, 3'd2, 32'h104, 64'd0, t0);
    issue(1'b0, 3'd6, 32'h104, 64'd0, t0);
    issue(1'b0, 3'd3, 32'h100, 64'd0, t0);
    issue(1'b1, 3'd1, 32'h102, 64'h0000_0000_0000_ABCD, t0);
    issue(1'b0, 3'd3, 32'h100, 64'd0, t1);
    chk("back_to_back_accept_gap", 64'(t1 - t0), 64'd5);
    issue(1'b1, 3'd3, 32'h108, 64'h0123_4567_89AB_CDEF, t0);
    issue(1'b0, 3'd2, 32'h102, 64'd0, t0);
    issue(1'b1, 3'd5, 32'h100, 64'd0, t0);
    issue(1'b0, 3'd7, 32'h100, 64'd0, t0);
    drain();

    // Reset while an SB sits in WAIT: write dropped, no response.
    saved = ref_mem[52];
    issue(1'b1, 3'd0, 32'h1A5, 64'h0000_0000_0000_005A, t0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_outs", {rsp_rdata | mem_wr_data}, 64'd0);
    chk("abort_ctrl", 64'({rsp_valid, rsp_err, mem_rd_en, mem_wr_en}), 64'd0);
    q.delete();
    ref_mem[52] = saved;
    nrd = 0; nwr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_mem_unchanged", mem[52], saved);
    issue(1'b0, 3'd3, 32'h1A0, 64'd0, t0);
    drain();

    // Randomized traffic, mostly aligned, with occasional idle gaps.
    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << (f3 % 4)) - 1);
      issue(we, f3, a, {$urandom(), $urandom()}, t0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain();

    for (int i = 0; i < 64; i++) chk($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
